uart_tx_param: RTL
==================

# uart_tx_param

Parametrised UART transmitter with a write-side FIFO, configurable frame format and hardware flow control. It accepts data words from the board-level logic, such as switch or button capture, and serialises them on `txd`. It replaces the fixed 8N1 single-word transmitter at the top level, adding selectable data width, parity, stop bits and queuing, plus `cts` gating and `rts` signalling.

## Interface
- `DATA_BITS`, 8: payload bits per frame, legal 5..9.
- `CLK_DIV`, 16: clock cycles per bit, ≥2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: word slots, power of 2, ≥2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe; sampled on the clock edge.
- `wr_data`  in  DATA_BITS  word to queue.
- `cts`  in  1  clear-to-send; high permits a new frame to start.
- `full`  out  1  FIFO holds FIFO_DEPTH words.
- `overflow`  out  1  one-cycle pulse when a write is dropped.
- `rts`  out  1  high while the FIFO is non-empty or a frame is in progress.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `txd`  out  1  serial line, idle high.

## Operation
- Reset values: `txd`=1, `rts`=0, `busy`=0, `full`=0, `overflow`=0. Reset clears the FIFO pointers and count and forces IDLE.
- Reset mid-frame aborts the frame. `txd` goes high asynchronously. No partial frame resumes after reset is released.
- FIFO write: a write is accepted when `wr_en` && !`full`.
  - `wr_en` && `full` drops the word and pulses `overflow` for 1 cycle.
  - There is no same-cycle bypass. A write while full is dropped even if a pop occurs in that cycle.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Transmit FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if the FIFO is non-empty and `cts`=1, pop the head into the shift register, clear the parity accumulator and go to START.
  - START: `txd`=0 for CLK_DIV cycles, then go to DATA.
  - DATA: shift out LSB first, one bit per CLK_DIV cycles, DATA_BITS bits. Parity accumulates the XOR of the sent bits. After the last bit go to PAR if PARITY≠0, else to STOP.
  - PAR: drive the XOR of the data bits for even parity, or its complement for odd parity, for CLK_DIV cycles.
  - STOP: `txd`=1 for STOP_BITS×CLK_DIV cycles. At the end, if the FIFO is non-empty and `cts`=1, pop and go directly to START with no idle bit. Otherwise go to IDLE.
- `cts` is checked only at frame start. Deasserting `cts` mid-frame does not stop the frame; the frame completes.
- The bit timer is a down-counter reloaded with CLK_DIV−1 on every bit boundary.
- `txd`, `busy` and `rts` are registered outputs.

## Timing
- Write accepted at edge k (FIFO empty, IDLE, `cts`=1):
  - FIFO non-empty from k+1.
  - Pop and state → START at edge k+1.
  - `txd` falls and `busy` and `rts` rise at edge k+2.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles.
- Back-to-back frames: the start bit follows the last stop-bit cycle with zero gap.
- `full` asserts the cycle after the write that fills the FIFO. It clears the cycle after a pop.
- `overflow` asserts in the cycle after the dropped write.
- `rts` falls on the same edge that `busy` falls, when the FIFO is empty.

## Test plan
- **Single frame, even parity.** DATA_BITS=8, CLK_DIV=4, PARITY=2, STOP_BITS=1. Write 0xA5. Required: `txd` per 4-cycle bit = 0, 1,0,1,0,0,1,0,1, 0 (parity), 1. The frame lasts 44 cycles starting 2 cycles after the write. `busy` stays high for exactly 44 cycles.
- **Odd parity, 2 stop bits, 7 data bits.** Write 0x03. Required: data bits 1,1,0,0,0,0,0, parity 1, stop high for 8 cycles. The frame lasts 44 cycles.
- **Back-to-back and overflow.** FIFO_DEPTH=4, `cts`=1. Write 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 on consecutive cycles. Required: `full` asserts. Exactly one write is dropped with one `overflow` pulse. Five frames go out with no idle gap. `rts` stays high throughout, then falls.
- **Flow control.** Hold `cts`=0 and write 0x5A. Required: `txd` stays 1 and `rts`=1. Raise `cts`; the frame starts 1 cycle later. Drop `cts` mid-frame; the frame still completes.
- **Async reset mid-frame.** Assert `rst` during the DATA state between clock edges. Required: `txd`=1 and `busy`=`rts`=`full`=0 immediately. After release, no frame is sent until a new write.
- **No parity, 5 bits.** CLK_DIV=2. Write 0x1F. Required: `txd` = 0, 1,1,1,1,1, 1, with each bit lasting 2 cycles, 14 cycles total.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: write-side FIFO, configurable data/parity/stop
// format, cts-gated frame start and rts/busy status.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 cts,
  output logic                 full,
  output logic                 overflow,
  output logic                 rts,
  output logic                 busy,
  output logic                 txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_overflow, r_ne_d;

  state_t               r_state, w_state_nx;
  logic [TW-1:0]        r_timer, w_timer_nx;
  logic [BW-1:0]        r_bitcnt, w_bit_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx;
  logic                 r_par, w_par_nx;
  logic                 r_txd, r_busy, r_rts;
  logic                 w_push, w_pop, w_empty, w_tick, w_txd_nx;

  assign full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = wr_en && !full;
  assign w_tick   = (r_timer == '0);
  assign overflow = r_overflow;
  assign txd      = r_txd;
  assign busy     = r_busy;
  assign rts      = r_rts;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  // A write while full is dropped even if the head is popped this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en && full;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= RELOAD;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_timer  <= w_timer_nx;
      r_bitcnt <= w_bit_nx;
      r_shift  <= w_shift_nx;
      r_par    <= w_par_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = w_tick ? RELOAD : r_timer - TW'(1);
    w_bit_nx   = r_bitcnt;
    w_shift_nx = r_shift;
    w_par_nx   = r_par;
    w_pop      = 1'b0;
    w_txd_nx   = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_timer_nx = RELOAD;
        if (!w_empty && cts) begin
          w_pop      = 1'b1;
          w_shift_nx = r_mem[r_rptr];
          w_par_nx   = 1'b0;
          w_bit_nx   = '0;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        w_txd_nx = 1'b0;
        if (w_tick) w_state_nx = S_DATA;
      end
      S_DATA: begin
        w_txd_nx = r_shift[0];
        if (w_tick) begin
          w_shift_nx = r_shift >> 1;
          w_par_nx   = r_par ^ r_shift[0];
          if (r_bitcnt == BW'(DATA_BITS - 1)) begin
            w_bit_nx   = '0;
            w_state_nx = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            w_bit_nx = r_bitcnt + BW'(1);
          end
        end
      end
      S_PAR: begin
        w_txd_nx = (PARITY == 1) ? ~r_par : r_par;
        if (w_tick) begin
          w_bit_nx   = '0;
          w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_bitcnt == BW'(STOP_BITS - 1)) begin
            w_bit_nx = '0;
            // Chain straight into the next start bit when more data is waiting.
            if (!w_empty && cts) begin
              w_pop      = 1'b1;
              w_shift_nx = r_mem[r_rptr];
              w_par_nx   = 1'b0;
              w_state_nx = S_START;
            end else begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_bit_nx = r_bitcnt + BW'(1);
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // rts uses a delayed non-empty flag so it rises together with busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txd  <= 1'b1;
      r_busy <= 1'b0;
      r_rts  <= 1'b0;
      r_ne_d <= 1'b0;
    end else begin
      r_txd  <= w_txd_nx;
      r_busy <= (r_state != S_IDLE);
      r_ne_d <= !w_empty;
      r_rts  <= (r_state != S_IDLE) || r_ne_d;
    end
  end
endmodule
